pc_unit: RTL and testbench

- Parametrised next-generation program counter for the single-cycle MIPS datapath.
- Holds the current fetch address and selects the next one internally, from these sources in priority order:
  - exception vector
  - stall hold
  - jump/branch/return redirect
  - sequential increment
- Adds an exception PC (EPC) register, a misalignment fault check, and a small return-address stack (RAS) for JAL/JR $ra.
- Feeds instruction memory; receives decoded control from the control unit and resolved targets from the branch/ALU logic.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pc_unit_if.sv | 38 +++
 rtl/ras_stack.sv | 85 ++++++++
 rtl/pc_unit.sv | 130 +++++++++++++
 tb/tb_pc_unit.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and next-PC source encoding for the fetch PC.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int unsigned DEF_WIDTH        = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0020;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int unsigned DEF_INSTR_BYTES  = 4;
  localparam int unsigned DEF_RAS_DEPTH    = 4;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_RET  = 3'd3,
    SRC_EXC  = 3'd4,
    SRC_HOLD = 3'd5
  } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_if
// Description : Control/target inputs and PC/status outputs of the fetch PC.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             exc_req;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump_en;
  logic [WIDTH-1:0] jump_target;
  logic             link_en;
  logic             ret_en;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] epc;
  logic             misalign_fault;
  logic             ras_empty;
  logic             ras_overflow;

  modport master (
    output stall, exc_req, branch_taken, branch_target, jump_en, jump_target,
           link_en, ret_en, reg_target,
    input  pc, pc_next_seq, epc, misalign_fault, ras_empty, ras_overflow
  );

  modport slave (
    input  stall, exc_req, branch_taken, branch_target, jump_en, jump_target,
           link_en, ret_en, reg_target,
    output pc, pc_next_seq, epc, misalign_fault, ras_empty, ras_overflow
  );
endinterface
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address LIFO; a push when full drops the oldest.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;

  // ptr_q is the next free slot; the top entry sits just below it.
  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == CNT_W'(RAS_DEPTH));
  assign w_do_pop  = pop_i && !w_empty;
  assign w_top_idx = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d    = ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    w_wr_idx = ptr_q;
    if (w_do_pop && push_i) begin
      // Call-through-return: the push reuses the slot the pop just freed.
      w_wr_idx = w_top_idx;
    end else if (w_do_pop) begin
      ptr_d   = w_top_idx;
      count_d = count_q - CNT_W'(1);
    end else if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (w_full) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_i) begin
      mem_q[w_wr_idx] <= push_data_i;
    end
  end

  assign top_o      = mem_q[w_top_idx];
  assign empty_o    = w_empty;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch program counter with exception vectoring, EPC capture,
//               target alignment check and a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned      INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int unsigned      RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_unit_if.slave   bus
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             fault_q, fault_d;

  pc_src_e          w_src;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_seq;
  logic             w_misaligned;
  logic             w_active;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_ovf;

  assign w_pc_seq = pc_q + STEP;
  assign w_active = !bus.exc_req && !bus.stall;
  assign w_push   = w_active && bus.link_en;
  assign w_pop    = w_active && bus.ret_en;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_pc_seq),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty),
    .overflow_o  (w_ras_ovf)
  );

  // Source selection in strict priority order.
  always_comb begin
    w_src    = SRC_SEQ;
    w_target = w_pc_seq;
    if (bus.exc_req) begin
      w_src    = SRC_EXC;
      w_target = EXC_VECTOR;
    end else if (bus.stall) begin
      w_src    = SRC_HOLD;
      w_target = pc_q;
    end else if (bus.ret_en) begin
      w_src    = SRC_RET;
      w_target = w_ras_empty ? bus.reg_target : w_ras_top;
    end else if (bus.jump_en) begin
      w_src    = SRC_JMP;
      w_target = bus.jump_target;
    end else if (bus.branch_taken) begin
      w_src    = SRC_BR;
      w_target = bus.branch_target;
    end
  end

  assign w_misaligned = ((w_src == SRC_RET) || (w_src == SRC_JMP) || (w_src == SRC_BR))
                        && (|(w_target & ALIGN_MASK));

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    fault_d = fault_q;
    case (w_src)
      SRC_EXC: begin
        pc_d    = EXC_VECTOR;
        epc_d   = pc_q;
        fault_d = 1'b0;
      end
      SRC_HOLD: begin
        pc_d    = pc_q;
      end
      default: begin
        if (w_misaligned) begin
          pc_d    = EXC_VECTOR;
          epc_d   = w_target;
          fault_d = 1'b1;
        end else begin
          pc_d    = w_target;
          fault_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_next_seq    = w_pc_seq;
  assign bus.epc            = epc_q;
  assign bus.misalign_fault = fault_q;
  assign bus.ras_empty      = w_ras_empty;
  assign bus.ras_overflow   = w_ras_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.exc_req = 0; bus.branch_taken = 0; bus.jump_en = 0;
    bus.link_en = 0; bus.ret_en = 0;
  endtask

  logic [31:0] jal_tgt [5];
  logic [31:0] jal_ret [5];

  initial begin
    idle();
    bus.branch_target = '0; bus.jump_target = '0; bus.reg_target = '0;
    rst_n = 0;
    tick(); tick();
    chk("rst_pc", bus.pc, 32'h0040_0020);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_fault", 32'(bus.misalign_fault), 32'd0);
    chk("rst_ras_empty", 32'(bus.ras_empty), 32'd1);
    chk("rst_ovf", 32'(bus.ras_overflow), 32'd0);

    rst_n = 1;
    tick(); chk("seq1", bus.pc, 32'h0040_0024);
    tick(); chk("seq2", bus.pc, 32'h0040_0028);
    tick(); chk("seq3", bus.pc, 32'h0040_002C);
    chk("seq_next", bus.pc_next_seq, 32'h0040_0030);

    // Branch held by stall, then taken.
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h0040_0100;
    tick(); chk("stall_hold", bus.pc, 32'h0040_002C);
    bus.stall = 0;
    tick(); chk("branch", bus.pc, 32'h0040_0100);
    idle();

    // JAL at 0x00400040 then return.
    bus.jump_en = 1; bus.jump_target = 32'h0040_0040;
    tick(); chk("jump", bus.pc, 32'h0040_0040);
    bus.link_en = 1; bus.jump_target = 32'h0040_1000;
    tick(); chk("jal", bus.pc, 32'h0040_1000);
    chk("jal_ras", 32'(bus.ras_empty), 32'd0);
    idle(); bus.ret_en = 1;
    tick(); chk("ret", bus.pc, 32'h0040_0044);
    chk("ret_ras_empty", 32'(bus.ras_empty), 32'd1);
    idle();

    // Five nested JALs overflow a four-entry stack.
    jal_tgt[0] = 32'h0040_2000; jal_ret[0] = 32'h0040_0048;
    jal_tgt[1] = 32'h0040_3000; jal_ret[1] = 32'h0040_2004;
    jal_tgt[2] = 32'h0040_4000; jal_ret[2] = 32'h0040_3004;
    jal_tgt[3] = 32'h0040_5000; jal_ret[3] = 32'h0040_4004;
    jal_tgt[4] = 32'h0040_6000; jal_ret[4] = 32'h0040_5004;
    for (int i = 0; i < 5; i++) begin
      bus.jump_en = 1; bus.link_en = 1; bus.jump_target = jal_tgt[i];
      tick(); chk("nest_jal", bus.pc, jal_tgt[i]);
      if (i == 3) chk("ovf_at_full", 32'(bus.ras_overflow), 32'd0);
    end
    chk("ovf_set", 32'(bus.ras_overflow), 32'd1);
    idle(); bus.ret_en = 1; bus.reg_target = 32'h0040_0500;
    for (int i = 4; i >= 1; i--) begin
      tick(); chk("nest_ret", bus.pc, jal_ret[i]);
    end
    chk("nest_empty", 32'(bus.ras_empty), 32'd1);
    tick(); chk("ret_fallback", bus.pc, 32'h0040_0500);
    chk("ovf_sticky", 32'(bus.ras_overflow), 32'd1);
    idle();

    // Exception with jump and link present: RAS must not change.
    bus.jump_en = 1; bus.link_en = 1; bus.jump_target = 32'h0040_0060;
    tick(); chk("jal2", bus.pc, 32'h0040_0060);
    bus.exc_req = 1; bus.jump_target = 32'h0040_0800;
    tick(); chk("exc_pc", bus.pc, 32'h8000_0180);
    chk("exc_epc", bus.epc, 32'h0040_0060);
    chk("exc_ras", 32'(bus.ras_empty), 32'd0);
    idle(); bus.ret_en = 1;
    tick(); chk("exc_ras_top", bus.pc, 32'h0040_0504);
    chk("exc_ras_drained", 32'(bus.ras_empty), 32'd1);
    idle();

    // Misaligned jump target.
    bus.jump_en = 1; bus.jump_target = 32'h0040_0102;
    tick(); chk("mis_pc", bus.pc, 32'h8000_0180);
    chk("mis_fault", 32'(bus.misalign_fault), 32'd1);
    chk("mis_epc", bus.epc, 32'h0040_0102);
    idle();
    tick(); chk("mis_clear_pc", bus.pc, 32'h8000_0184);
    chk("mis_clear", 32'(bus.misalign_fault), 32'd0);

    // Reset wins over exception and stall.
    rst_n = 0; bus.exc_req = 1; bus.stall = 1;
    tick(); chk("rst2_pc", bus.pc, 32'h0040_0020);
    chk("rst2_epc", bus.epc, 32'h0);
    chk("rst2_ovf", 32'(bus.ras_overflow), 32'd0);
    rst_n = 1; idle();

    // Wraparound of the sequential increment.
    bus.jump_en = 1; bus.jump_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_next", bus.pc_next_seq, 32'h0);
    idle();
    tick(); chk("wrap", bus.pc, 32'h0);

    // Simultaneous pop and push keeps depth.
    bus.jump_en = 1; bus.link_en = 1; bus.jump_target = 32'h0040_0200;
    tick(); chk("cr_jal", bus.pc, 32'h0040_0200);
    bus.ret_en = 1;
    tick(); chk("cr_ret", bus.pc, 32'h0000_0004);
    chk("cr_depth", 32'(bus.ras_empty), 32'd0);
    idle(); bus.ret_en = 1;
    tick(); chk("cr_ret2", bus.pc, 32'h0040_0204);
    chk("cr_empty", 32'(bus.ras_empty), 32'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
